// File: rtl/ipi_mailbox_rr_pkg.sv
// Shared definitions for the ipi_mailbox_rr inter-processor mailbox:
// register selects, STATUS/IRQ_CTRL field positions and source-ID width helper.
package ipi_mbox_pkg;

    localparam logic [2:0] SEL_SEND_MASK = 3'd0;
    localparam logic [2:0] SEL_TX_DATA   = 3'd1;
    localparam logic [2:0] SEL_RX_DATA   = 3'd2;
    localparam logic [2:0] SEL_STATUS    = 3'd3;
    localparam logic [2:0] SEL_IRQ_CTRL  = 3'd4;
    localparam logic [2:0] SEL_RX_SRC    = 3'd5;
    localparam logic [2:0] SEL_TX_ERR    = 3'd6;
    localparam logic [2:0] SEL_RSVD      = 3'd7;

    localparam int STAT_NONEMPTY_BIT = 0;
    localparam int STAT_FULL_BIT     = 1;
    localparam int STAT_IRQ_BIT      = 2;
    localparam int STAT_LEVEL_LSB    = 8;
    localparam int STAT_LEVEL_W      = 8;

    localparam int IRQ_EN_BIT  = 0;
    localparam int IRQ_THR_LSB = 8;
    localparam int IRQ_THR_W   = 8;

    // Width of the sender tag stored alongside each message word.
    function automatic int src_w(input int cores);
        return (cores > 1) ? $clog2(cores) : 1;
    endfunction

endpackage

// File: rtl/csr_if.sv
// Per-core CSR request/response channel used by the mailbox.
interface csr_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_fault;
    logic              rsp_side_effect;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_side_effect
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_side_effect
    );
endinterface

// File: rtl/ipi_mailbox_rr_fifo.sv
// mailbox_fifo: per-core RX storage; occupancy is tracked by the parent, which
// guarantees no push when full and no pop when empty.
module mailbox_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: the parent never reads an empty FIFO's head.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ipi_mailbox_rr.sv
// ipi_mailbox_rr: multi-core mailbox with atomic multicast TX, fill tracking and
// watermark IRQs. Define IPI_MBOX_RR_ARB_EN for round-robin sender arbitration.
module ipi_mailbox_rr
    import ipi_mbox_pkg::*;
#(
    parameter int CORES      = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    csr_if.slave             csr [CORES],
    output logic [CORES-1:0] ipi_irq
);
    localparam int SRC_W   = src_w(CORES);
    localparam int ENTRY_W = DATA_W + SRC_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic [CORES-1:0]   req_valid;
    logic [CORES-1:0]   req_write;
    logic [CORES-1:0]   req_ready;
    logic [CORES-1:0]   tx_req;
    logic [CORES-1:0]   tx_accept;
    logic [CORES-1:0]   fifo_full;
    logic [CORES-1:0]   push;
    logic [CORES-1:0]   pop;
    logic [2:0]         sel        [CORES];
    logic [DATA_W-1:0]  wdata      [CORES];
    logic [CORES-1:0]   send_mask  [CORES];
    logic [ENTRY_W-1:0] push_entry [CORES];
    logic [ENTRY_W-1:0] head_entry [CORES];
    logic [SRC_W-1:0]   scan_start;

    // A sender wins only if all its targets have room and none was already
    // claimed by a higher-priority sender, so delivery is all-or-nothing.
    always_comb begin
        logic [CORES-1:0] claimed;
        logic [SRC_W-1:0] idx_s;
        int               idx;
        claimed   = '0;
        tx_accept = '0;
        push      = '0;
        idx_s     = '0;
        idx       = 0;
        for (int t = 0; t < CORES; t++) push_entry[t] = '0;
        for (int i = 0; i < CORES; i++) begin
            idx = int'(scan_start) + i;
            if (idx >= CORES) idx = idx - CORES;
            idx_s = SRC_W'(idx);
            if (tx_req[idx_s] && ((send_mask[idx_s] & (fifo_full | claimed)) == '0)) begin
                tx_accept[idx_s] = 1'b1;
                claimed          = claimed | send_mask[idx_s];
                for (int t = 0; t < CORES; t++) begin
                    if (send_mask[idx_s][t]) begin
                        push[t]       = 1'b1;
                        push_entry[t] = {idx_s, wdata[idx_s]};
                    end
                end
            end
        end
    end

`ifdef IPI_MBOX_RR_ARB_EN
    logic [SRC_W-1:0] rr_ptr_q;
    logic [SRC_W-1:0] first_idx;

    // Downward scan so the last hit is the first accepted sender in rr order.
    always_comb begin
        int idx;
        first_idx = '0;
        idx       = 0;
        for (int i = CORES - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= CORES) idx = idx - CORES;
            if (tx_accept[SRC_W'(idx)]) first_idx = SRC_W'(idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (|tx_accept) begin
            rr_ptr_q <= (first_idx == SRC_W'(CORES - 1)) ? '0 : first_idx + SRC_W'(1);
        end
    end

    assign scan_start = rr_ptr_q;
`else
    assign scan_start = '0;
`endif

    for (genvar g = 0; g < CORES; g++) begin : g_core
        logic               accept;
        logic               empty;
        logic               fault_c;
        logic [DATA_W-1:0]  rdata_c;
        logic               rsp_valid_q;
        logic [DATA_W-1:0]  rsp_rdata_q;
        logic               rsp_fault_q;
        logic               rsp_se_q;
        logic [CORES-1:0]   send_mask_q;
        logic               irq_en_q;
        logic [IRQ_THR_W-1:0] irq_thr_q;
        logic [IRQ_THR_W-1:0] thr_eff;
        logic               tx_err_q;
        logic [CNT_W-1:0]   count_q;
        logic               irq_q;

        assign req_valid[g] = csr[g].req_valid;
        assign req_write[g] = csr[g].req_write;
        assign sel[g]       = csr[g].req_addr[4:2];
        assign wdata[g]     = csr[g].req_wdata;
        assign send_mask[g] = send_mask_q;

        assign empty        = (count_q == '0);
        assign fifo_full[g] = (count_q == CNT_W'(FIFO_DEPTH));
        assign tx_req[g]    = req_valid[g] && req_write[g] && (sel[g] == SEL_TX_DATA)
                              && (send_mask_q != '0);
        assign req_ready[g] = !rsp_valid_q && (!tx_req[g] || tx_accept[g]);
        assign accept       = req_valid[g] && req_ready[g];
        assign pop[g]       = accept && !req_write[g] && (sel[g] == SEL_RX_DATA) && !empty;

        assign csr[g].req_ready       = req_ready[g];
        assign csr[g].rsp_valid       = rsp_valid_q;
        assign csr[g].rsp_rdata       = rsp_rdata_q;
        assign csr[g].rsp_fault       = rsp_fault_q;
        assign csr[g].rsp_side_effect = rsp_se_q;
        assign ipi_irq[g]             = irq_q;

        always_comb begin
            fault_c = 1'b0;
            rdata_c = '0;
            case (sel[g])
                SEL_SEND_MASK: if (!req_write[g]) rdata_c = DATA_W'(send_mask_q);
                SEL_TX_DATA:   fault_c = !req_write[g] || (send_mask_q == '0);
                SEL_RX_DATA: begin
                    if (req_write[g] || empty) fault_c = 1'b1;
                    else                       rdata_c = head_entry[g][DATA_W-1:0];
                end
                SEL_STATUS: begin
                    if (req_write[g]) begin
                        fault_c = 1'b1;
                    end else begin
                        rdata_c[STAT_NONEMPTY_BIT] = !empty;
                        rdata_c[STAT_FULL_BIT]     = fifo_full[g];
                        rdata_c[STAT_IRQ_BIT]      = irq_q;
                        rdata_c[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(count_q);
                    end
                end
                SEL_IRQ_CTRL: begin
                    if (!req_write[g]) begin
                        rdata_c[IRQ_EN_BIT]                 = irq_en_q;
                        rdata_c[IRQ_THR_LSB +: IRQ_THR_W]   = irq_thr_q;
                    end
                end
                SEL_RX_SRC: begin
                    if (req_write[g])  fault_c = 1'b1;
                    else if (!empty)   rdata_c = DATA_W'(head_entry[g][ENTRY_W-1 -: SRC_W]);
                end
                SEL_TX_ERR: if (!req_write[g]) rdata_c[0] = tx_err_q;
                default:    fault_c = 1'b1;
            endcase
        end

        // Response is captured at acceptance and held until the core takes it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rsp_valid_q <= 1'b0;
                rsp_rdata_q <= '0;
                rsp_fault_q <= 1'b0;
                rsp_se_q    <= 1'b0;
            end else if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rdata_c;
                rsp_fault_q <= fault_c;
                rsp_se_q    <= req_write[g] || pop[g];
            end else if (rsp_valid_q && csr[g].rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end

        // A TX with an empty mask faults yet still latches the sticky error.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                send_mask_q <= '0;
                irq_en_q    <= 1'b0;
                irq_thr_q   <= '0;
                tx_err_q    <= 1'b0;
            end else if (accept && req_write[g]) begin
                if (!fault_c) begin
                    case (sel[g])
                        SEL_SEND_MASK: send_mask_q <= wdata[g][CORES-1:0];
                        SEL_IRQ_CTRL: begin
                            irq_en_q  <= wdata[g][IRQ_EN_BIT];
                            irq_thr_q <= wdata[g][IRQ_THR_LSB +: IRQ_THR_W];
                        end
                        SEL_TX_ERR: if (wdata[g][0]) tx_err_q <= 1'b0;
                        default: ;
                    endcase
                end else if (sel[g] == SEL_TX_DATA) begin
                    tx_err_q <= 1'b1;
                end
            end
        end

        assign thr_eff = (irq_thr_q == '0) ? IRQ_THR_W'(1) : irq_thr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count_q <= '0;
                irq_q   <= 1'b0;
            end else begin
                if (push[g] && !pop[g])      count_q <= count_q + CNT_W'(1);
                else if (pop[g] && !push[g]) count_q <= count_q - CNT_W'(1);
                irq_q <= irq_en_q && (16'(count_q) >= 16'(thr_eff));
            end
        end

        mailbox_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[g]),
            .push_data (push_entry[g]),
            .pop       (pop[g]),
            .head_data (head_entry[g])
        );
    end

endmodule

// File: tb/tb_ipi_mailbox_rr.sv
// Directed self-checking bench for ipi_mailbox_rr (4 cores, 32-bit words, depth 8).
module tb_ipi_mailbox_rr;
    import ipi_mbox_pkg::*;

    localparam int CORES = 4;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int LIMIT = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [CORES-1:0] req_valid, req_write, rsp_ready;
    logic [CORES-1:0] req_ready, rsp_valid, rsp_fault, rsp_side_effect, ipi_irq;
    logic [AW-1:0]    req_addr  [CORES];
    logic [DW-1:0]    req_wdata [CORES];
    logic [DW-1:0]    rsp_rdata [CORES];

    int tests_run    = 0;
    int tests_failed = 0;

    csr_if #(.DATA_W(DW), .ADDR_W(AW)) csr [CORES] ();

    for (genvar g = 0; g < CORES; g++) begin : g_conn
        assign csr[g].req_valid  = req_valid[g];
        assign csr[g].req_write  = req_write[g];
        assign csr[g].req_addr   = req_addr[g];
        assign csr[g].req_wdata  = req_wdata[g];
        assign csr[g].rsp_ready  = rsp_ready[g];
        assign req_ready[g]       = csr[g].req_ready;
        assign rsp_valid[g]       = csr[g].rsp_valid;
        assign rsp_rdata[g]       = csr[g].rsp_rdata;
        assign rsp_fault[g]       = csr[g].rsp_fault;
        assign rsp_side_effect[g] = csr[g].rsp_side_effect;
    end

    ipi_mailbox_rr #(
        .CORES      (CORES),
        .DATA_W     (DW),
        .FIFO_DEPTH (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .csr     (csr),
        .ipi_irq (ipi_irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic startReq(input int c, input bit wr, input logic [2:0] sel, input logic [31:0] wd);
        req_write[c] = wr;
        req_addr[c]  = {3'b000, sel, 2'b00};
        req_wdata[c] = wd;
        req_valid[c] = 1'b1;
    endtask

    task automatic clearRsp(input int c);
        rsp_ready[c] = 1'b1;
        stepCycle();
        rsp_ready[c] = 1'b0;
    endtask

    // Full CSR transaction: wait for ready (bounded), capture response, release it.
    task automatic applyStimulus(input int c, input bit wr, input logic [2:0] sel,
                                 input logic [31:0] wd, output logic [31:0] rd,
                                 output logic flt, output logic se);
        int n;
        n = 0;
        startReq(c, wr, sel, wd);
        #1;
        while (!req_ready[c] && n < LIMIT) begin
            stepCycle();
            n++;
        end
        if (n >= LIMIT) checkOutput("req_ready_timeout", 32'(n), 32'(0));
        stepCycle();
        req_valid[c] = 1'b0;
        rd  = rsp_rdata[c];
        flt = rsp_fault[c];
        se  = rsp_side_effect[c];
        clearRsp(c);
    endtask

    task automatic csrRead(input int c, input logic [2:0] sel, input logic [31:0] exp_d,
                           input logic exp_f, input string tag);
        logic [31:0] d;
        logic f, s;
        applyStimulus(c, 1'b0, sel, 32'h0, d, f, s);
        checkOutput({tag, "_data"},  d, exp_d);
        checkOutput({tag, "_fault"}, 32'(f), 32'(exp_f));
    endtask

    task automatic csrWrite(input int c, input logic [2:0] sel, input logic [31:0] wd,
                            input logic exp_f, input string tag);
        logic [31:0] d;
        logic f, s;
        applyStimulus(c, 1'b1, sel, wd, d, f, s);
        checkOutput({tag, "_fault"}, 32'(f), 32'(exp_f));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first, second;
        logic [31:0] tx_word [2];
        logic [31:0] d;
        logic f, s;

        req_valid = '0;
        req_write = '0;
        rsp_ready = '0;
        for (int i = 0; i < CORES; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_irq",       32'(ipi_irq),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("idle_req_ready", 32'(req_ready), 32'hF);
        csrRead(0, SEL_SEND_MASK, 32'h0, 1'b0, "rst_mask");
        csrRead(0, SEL_STATUS,    32'h0, 1'b0, "rst_status");

        // Multicast to cores 1 and 2
        csrWrite(0, SEL_SEND_MASK, 32'h0000_0006, 1'b0, "mc_mask");
        csrWrite(0, SEL_TX_DATA,   32'hA5A5_0001, 1'b0, "mc_tx");
        csrRead(1, SEL_STATUS,  32'h0000_0101, 1'b0, "mc_c1_status");
        csrRead(1, SEL_RX_SRC,  32'h0,         1'b0, "mc_c1_src");
        applyStimulus(1, 1'b0, SEL_RX_DATA, 32'h0, d, f, s);
        checkOutput("mc_c1_rx_data", d, 32'hA5A5_0001);
        checkOutput("mc_c1_rx_se",   32'(s), 32'h1);
        csrRead(2, SEL_STATUS,  32'h0000_0101, 1'b0, "mc_c2_status");
        csrRead(2, SEL_RX_DATA, 32'hA5A5_0001, 1'b0, "mc_c2_rx");
        applyStimulus(3, 1'b0, SEL_STATUS, 32'h0, d, f, s);
        checkOutput("mc_c3_status", d, 32'h0);
        checkOutput("mc_c3_se",     32'(s), 32'h0);

        // Cores 0 and 1 contend for core 3 in the same cycle
        csrWrite(0, SEL_SEND_MASK, 32'h8, 1'b0, "arb_mask0");
        csrWrite(1, SEL_SEND_MASK, 32'h8, 1'b0, "arb_mask1");
`ifdef IPI_MBOX_RR_ARB_EN
        first = 1;
`else
        first = 0;
`endif
        second = 1 - first;
        tx_word[0] = 32'h0000_1000;
        tx_word[1] = 32'h0000_2001;
        startReq(0, 1'b1, SEL_TX_DATA, tx_word[0]);
        startReq(1, 1'b1, SEL_TX_DATA, tx_word[1]);
        #1;
        checkOutput("arb_ready0", 32'(req_ready[0]), 32'(first == 0));
        checkOutput("arb_ready1", 32'(req_ready[1]), 32'(first == 1));
        stepCycle();
        req_valid[first] = 1'b0;
        #1;
        checkOutput("arb_second_ready", 32'(req_ready[second]), 32'h1);
        stepCycle();
        req_valid[second] = 1'b0;
        clearRsp(0);
        clearRsp(1);
        csrRead(3, SEL_STATUS,  32'h0000_0201,     1'b0, "arb_c3_status");
        csrRead(3, SEL_RX_SRC,  32'(first),        1'b0, "arb_src_a");
        csrRead(3, SEL_RX_DATA, tx_word[first],    1'b0, "arb_data_a");
        csrRead(3, SEL_RX_SRC,  32'(second),       1'b0, "arb_src_b");
        csrRead(3, SEL_RX_DATA, tx_word[second],   1'b0, "arb_data_b");

        // Back-pressure from a full target
        csrWrite(0, SEL_SEND_MASK, 32'h2, 1'b0, "full_mask");
        for (int i = 0; i < 8; i++) csrWrite(0, SEL_TX_DATA, 32'h100 + 32'(i), 1'b0, "full_fill");
        csrRead(1, SEL_STATUS, 32'h0000_0803, 1'b0, "full_status");
        startReq(0, 1'b1, SEL_TX_DATA, 32'h0000_BEEF);
        #1;
        checkOutput("full_block0", 32'(req_ready[0]), 32'h0);
        stepCycle();
        checkOutput("full_block1", 32'(req_ready[0]), 32'h0);
        startReq(1, 1'b0, SEL_RX_DATA, 32'h0);
        stepCycle();
        req_valid[1] = 1'b0;
        checkOutput("full_pop_data", rsp_rdata[1], 32'h100);
        checkOutput("full_unblock",  32'(req_ready[0]), 32'h1);
        stepCycle();
        req_valid[0] = 1'b0;
        checkOutput("full_tx_fault", 32'(rsp_fault[0]), 32'h0);
        clearRsp(0);
        clearRsp(1);
        csrRead(1, SEL_STATUS, 32'h0000_0803, 1'b0, "refill_status");
        for (int i = 1; i <= 8; i++)
            csrRead(1, SEL_RX_DATA, (i < 8) ? 32'h100 + 32'(i) : 32'h0000_BEEF, 1'b0, "drain");

        // Watermark interrupt on core 2
        csrWrite(2, SEL_IRQ_CTRL, 32'h0000_0301, 1'b0, "irq_ctrl_wr");
        csrRead(2, SEL_IRQ_CTRL, 32'h0000_0301, 1'b0, "irq_ctrl_rd");
        csrWrite(0, SEL_SEND_MASK, 32'h4, 1'b0, "irq_mask");
        csrWrite(0, SEL_TX_DATA, 32'h300, 1'b0, "irq_tx0");
        csrWrite(0, SEL_TX_DATA, 32'h301, 1'b0, "irq_tx1");
        checkOutput("irq_below", 32'(ipi_irq[2]), 32'h0);
        startReq(0, 1'b1, SEL_TX_DATA, 32'h302);
        stepCycle();
        req_valid[0] = 1'b0;
        checkOutput("irq_lag",    32'(ipi_irq[2]), 32'h0);
        stepCycle();
        checkOutput("irq_assert", 32'(ipi_irq[2]), 32'h1);
        clearRsp(0);
        csrRead(2, SEL_STATUS, 32'h0000_0305, 1'b0, "irq_status");
        startReq(2, 1'b0, SEL_RX_DATA, 32'h0);
        stepCycle();
        req_valid[2] = 1'b0;
        checkOutput("irq_pop_data",  rsp_rdata[2], 32'h300);
        checkOutput("irq_hold",      32'(ipi_irq[2]), 32'h1);
        stepCycle();
        checkOutput("irq_deassert",  32'(ipi_irq[2]), 32'h0);
        clearRsp(2);

        // Empty send mask and sticky TX error
        csrWrite(3, SEL_TX_DATA, 32'h77, 1'b1, "txerr_tx");
        csrRead(3, SEL_TX_ERR, 32'h1, 1'b0, "txerr_set");
        csrRead(3, SEL_STATUS, 32'h0, 1'b0, "txerr_no_push");
        csrWrite(3, SEL_TX_ERR, 32'h1, 1'b0, "txerr_clr");
        csrRead(3, SEL_TX_ERR, 32'h0, 1'b0, "txerr_cleared");

        // Faulting accesses
        csrRead(3, SEL_RX_DATA, 32'h0, 1'b1, "empty_rx");
        csrRead(3, SEL_STATUS,  32'h0, 1'b0, "empty_rx_count");
        csrRead(3, SEL_RX_SRC,  32'h0, 1'b0, "empty_src");
        csrRead(3, SEL_RSVD,    32'h0, 1'b1, "rsvd_rd");
        csrRead(0, SEL_TX_DATA, 32'h0, 1'b1, "txdata_rd");
        csrWrite(1, SEL_STATUS, 32'hFFFF, 1'b1, "status_wr");
        csrWrite(0, SEL_RSVD,   32'hF, 1'b1, "rsvd_wr");
        csrRead(0, SEL_SEND_MASK, 32'h4, 1'b0, "fault_no_change");

        // Asynchronous reset while a response is held
        csrWrite(2, SEL_IRQ_CTRL, 32'h0000_0101, 1'b0, "pre_rst_irq_ctrl");
        checkOutput("pre_rst_irq", 32'(ipi_irq), 32'h4);
        startReq(0, 1'b0, SEL_SEND_MASK, 32'h0);
        stepCycle();
        req_valid[0] = 1'b0;
        checkOutput("pre_rst_rsp_valid", 32'(rsp_valid[0]), 32'h1);
        checkOutput("pre_rst_rsp_data",  rsp_rdata[0], 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("arst_irq",       32'(ipi_irq),   32'h0);
        checkOutput("arst_rdata",     rsp_rdata[0],   32'h0);
        checkOutput("arst_fault",     32'(rsp_fault), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle();
        csrRead(2, SEL_STATUS,    32'h0, 1'b0, "post_rst_status");
        csrRead(0, SEL_SEND_MASK, 32'h0, 1'b0, "post_rst_mask");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
